// File: rtl/fetch2_decode_queue_pkg.sv
// Shared core types for the fetch-stage-2 to decode bundle queue.
// Holds the per-lane decode packet layout and the default fetch width.
package fetch2_decode_queue_pkg;

  localparam int FETCH_WIDTH = 4;

  typedef struct packed {
    logic [7:0]  seqNo;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [2:0]  ctrlType;
    logic [31:0] predNPC;
    logic        predDir;
    logic [3:0]  ctiID;
    logic        exception;
    logic [3:0]  exceptionCause;
    logic        valid;
  } decPkt;

endpackage

// File: rtl/fetch2_decode_queue_if.sv
// Fetch-side push and decode-side pop signals of the bundle queue.
// The queue uses the slave modport; its environment uses the master modport.
interface fetch2_decode_queue_if
  import fetch2_decode_queue_pkg::*;
#(
  parameter int FETCH_WIDTH = fetch2_decode_queue_pkg::FETCH_WIDTH,
  parameter int DEPTH       = 4
);

  logic                       fs2Valid_i;
  decPkt [FETCH_WIDTH-1:0]    decPacket_i;
  logic                       decReady_i;
  decPkt [FETCH_WIDTH-1:0]    decPacket_o;
  logic                       decValid_o;
  logic                       queueFull_o;
  logic [$clog2(DEPTH):0]     occupancy_o;
  logic                       overflowErr_o;

  modport master (
    output fs2Valid_i, decPacket_i, decReady_i,
    input  decPacket_o, decValid_o, queueFull_o, occupancy_o, overflowErr_o
  );

  modport slave (
    input  fs2Valid_i, decPacket_i, decReady_i,
    output decPacket_o, decValid_o, queueFull_o, occupancy_o, overflowErr_o
  );

endinterface

// File: rtl/fetch2_decode_ram.sv
// Bundle storage: one synchronous write port at the tail, one asynchronous read port at the head.
// Contents are not reset; validity is tracked by the queue occupancy.
module fetch2_decode_ram
  import fetch2_decode_queue_pkg::*;
#(
  parameter int FETCH_WIDTH = fetch2_decode_queue_pkg::FETCH_WIDTH,
  parameter int DEPTH       = 4
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [$clog2(DEPTH)-1:0]     waddr,
  input  decPkt [FETCH_WIDTH-1:0]      wdata,
  input  logic [$clog2(DEPTH)-1:0]     raddr,
  output decPkt [FETCH_WIDTH-1:0]      rdata
);

  decPkt [FETCH_WIDTH-1:0] mem_r [DEPTH];

  // Write the incoming bundle into the tail entry.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/fetch2_decode_queue.sv
// Bundle FIFO between fetch stage 2 and decode with flush, backpressure and a sticky overflow flag.
// Outputs are derived from registered pointer/occupancy state only; there is no bypass path.
module fetch2_decode_queue
  import fetch2_decode_queue_pkg::*;
#(
  parameter int FETCH_WIDTH = fetch2_decode_queue_pkg::FETCH_WIDTH,
  parameter int DEPTH       = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  recoverFlag_i,
  input  logic                  exceptionFlag_i,
  fetch2_decode_queue_if.slave  bus
);

  localparam int             AW         = $clog2(DEPTH);
  localparam logic [AW-1:0]  PTR_ONE    = AW'(1);
  localparam logic [AW:0]    OCC_ONE    = (AW+1)'(1);
  localparam logic [AW:0]    FULL_COUNT = (AW+1)'(DEPTH);

  logic [AW-1:0]            head_r;
  logic [AW-1:0]            tail_r;
  logic [AW:0]              occ_r;
  logic                     ovf_r;

  logic                     flush_s;
  logic                     any_lane_s;
  logic                     full_s;
  logic                     nonempty_s;
  logic                     push_s;
  logic                     pop_s;
  decPkt [FETCH_WIDTH-1:0]  head_pkt_s;
  decPkt [FETCH_WIDTH-1:0]  out_pkt_s;

  // OR-reduce the per-lane valid bits of the incoming bundle.
  always_comb begin
    any_lane_s = 1'b0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      any_lane_s = any_lane_s | bus.decPacket_i[i].valid;
    end
  end

  assign flush_s    = recoverFlag_i | exceptionFlag_i;
  assign full_s     = (occ_r == FULL_COUNT);
  assign nonempty_s = (occ_r != {(AW+1){1'b0}});
  // Full is judged on registered occupancy, so a same-cycle pop never frees room for a push.
  assign push_s     = bus.fs2Valid_i & ~full_s & ~flush_s & any_lane_s;
  assign pop_s      = nonempty_s & bus.decReady_i & ~flush_s;

  // Head/tail pointers and occupancy; flush empties the queue like reset does.
  always_ff @(posedge clk) begin
    if (reset || flush_s) begin
      head_r <= {AW{1'b0}};
      tail_r <= {AW{1'b0}};
      occ_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_s) begin
        tail_r <= tail_r + PTR_ONE;
      end else begin
        tail_r <= tail_r;
      end
      if (pop_s) begin
        head_r <= head_r + PTR_ONE;
      end else begin
        head_r <= head_r;
      end
      case ({push_s, pop_s})
        2'b10:   occ_r <= occ_r + OCC_ONE;
        2'b01:   occ_r <= occ_r - OCC_ONE;
        default: occ_r <= occ_r;
      endcase
    end
  end

  // Sticky protocol error: fetch presented a bundle while the queue was full.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_r <= 1'b0;
    end else if (bus.fs2Valid_i && full_s && !flush_s) begin
      ovf_r <= 1'b1;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  fetch2_decode_ram #(
    .FETCH_WIDTH (FETCH_WIDTH),
    .DEPTH       (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (push_s),
    .waddr (tail_r),
    .wdata (bus.decPacket_i),
    .raddr (head_r),
    .rdata (head_pkt_s)
  );

  // Stale storage must not look valid when the queue is empty.
  always_comb begin
    out_pkt_s = head_pkt_s;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      out_pkt_s[i].valid = head_pkt_s[i].valid & nonempty_s;
    end
  end

  assign bus.decPacket_o   = out_pkt_s;
  assign bus.decValid_o    = nonempty_s;
  assign bus.queueFull_o   = full_s;
  assign bus.occupancy_o   = occ_r;
  assign bus.overflowErr_o = ovf_r;

endmodule
